clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//   Multi-channel, run-time programmable integer clock divider. Successor to the
//   fixed divide-by-constant generator used for the FIFO read/write clocks.
//   Each channel produces a divided clock with near-50% duty, a one-cycle tick
//   strobe, and glitch-free start, stop and divisor change.
//   Sits between the system clock source and the FIFO and peripheral clock domains.
// PARAMETERS
//   NUM_CH   2   number of independent divider channels (1..16)
//   CNT_W    8   divisor/counter width; legal divisor 2..2^CNT_W-1
//   DEF_DIV  4   divisor loaded into every channel at reset (2..2^CNT_W-1)
//   CH_W     $clog2(NUM_CH) (min 1)  channel-select width (localparam)
// PORTS
//   clk         in   1              system clock; all logic on posedge clk
//   reset       in   1              asynchronous, active-high
//   cfg_we      in   1              config write strobe, one cycle
//   cfg_ch      in   CH_W           target channel for cfg write
//   cfg_div     in   CNT_W          requested divisor N
//   cfg_err     out  1              1-cycle pulse: last cfg write rejected
//   ch_en       in   NUM_CH         per-channel run enable (level)
//   clk_out     out  NUM_CH         divided clocks (registered)
//   tick        out  NUM_CH         1-cycle pulse coincident with clk_out rise
//   running     out  NUM_CH         channel in RUN state
// BEHAVIOUR
//   Reset (async): clk_out=0, tick=0, running=0, cfg_err=0, every div_act=DEF_DIV,
//     pend_valid=0, cnt=0, state=IDLE. Asserting reset mid-period forces outputs
//     low immediately. Operation resumes on the first posedge after release.
//   Divide: period = N clk cycles. clk_out is high for H=(N+1)>>1 cycles,
//     then low for N-H cycles. Examples: N=2 gives 1H/1L, N=3 gives 2H/1L,
//     N=4 gives 2H/2L.
//   Per-channel registers: cnt[CNT_W], div_act, div_pend, pend_valid, state.
//   FSM per channel:
//     IDLE: clk_out=0, cnt=0. If ch_en=1: next cycle go to RUN, cnt<=0,
//       clk_out<=1, tick<=1. div_act<=div_pend if pend_valid, and clear pend_valid.
//     RUN, cnt!=div_act-1: cnt<=cnt+1; clk_out<=((cnt+1)<H).
//     RUN, cnt==div_act-1 (wrap):
//       - If pend_valid: div_act<=div_pend and clear pend_valid.
//       - If ch_en=1: cnt<=0, clk_out<=1, tick<=1.
//       - Else: go to IDLE, clk_out<=0.
//   Deasserting ch_en mid-period never truncates a pulse. The period always
//     completes before the channel parks low.
//   Config write (cfg_we=1):
//     - Legal if cfg_ch<NUM_CH and cfg_div>=2: div_pend<=cfg_div, pend_valid<=1.
//     - Otherwise: no state change, and cfg_err=1 on the next cycle.
//     - The new divisor never takes effect mid-period. It applies at the next
//       wrap or at the IDLE->RUN start.
//     - A write in the same cycle as a wrap is pended and applied at the
//       following wrap.
//     - Back-to-back writes to one channel before a wrap: last write wins.
//   Channels are fully independent. Simultaneous ch_en changes on different
//     channels are all honoured in the same cycle.
//   Counter never exceeds div_act-1. No overflow is possible for legal N.
// TESTING
//   1. Reset release, ch_en=01, DEF_DIV=4 -> ch0 clk_out 1,1,0,0 repeating;
//      tick every 4th cycle; ch1 stays 0 and running[1]=0.
//   2. Odd divide: write ch0 N=5 while IDLE, then enable -> 3 high/2 low,
//      period 5, tick on each rise.
//   3. Write N=3 to running ch0 at cnt=1 of an N=4 period -> current period
//      completes as 4 cycles; next period is 2H/1L.
//   4. Drop ch_en at cnt=0 of N=6 -> 3 high + 3 low complete, then clk_out=0,
//      running=0; re-enable -> rise on next cycle.
//   5. cfg_div=1, and cfg_ch=NUM_CH (NUM_CH=3) -> cfg_err pulse each; divisor
//      and output waveform unchanged.
//   6. Assert reset mid-high-phase -> clk_out/tick low immediately; after
//      release with ch_en=1, channel restarts with DEF_DIV and the pending
//      value discarded.

Source files
------------

// File: rtl/clk_div_prog.sv
// clk_div_prog: multi-channel run-time programmable integer clock divider.
// Each channel emits a registered divided clock (high for (N+1)>>1 cycles of
// every N), a one-cycle tick on each rising edge of that clock, and a running
// flag. Divisor changes are pended and only take effect on a period boundary,
// and disabling a channel always lets the current period finish.
module clk_div_prog #(
   parameter int unsigned NUM_CH  = 2,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned DEF_DIV = 4,
   localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   output logic              cfg_err,
   input  logic [NUM_CH-1:0] ch_en,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] running
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [CH_W:0]    NUM_CH_L  = NUM_CH[CH_W:0];
   localparam logic [CNT_W-1:0] DEF_DIV_L = DEF_DIV[CNT_W-1:0];
   localparam logic [CNT_W-1:0] MIN_DIV   = CNT_W'(2);

   // A write is accepted only for an existing channel and a divisor of two or more.
   logic cfg_legal;

   // Shared write qualification, decoded once for all channels.
   always_comb begin
      cfg_legal = cfg_we && ({1'b0, cfg_ch} < NUM_CH_L) && (cfg_div >= MIN_DIV);
   end

   // Rejected writes are reported one cycle later as a single-cycle pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfg_we && !cfg_legal;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      state_t           state;
      state_t           state_nxt;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] div_act;
      logic [CNT_W-1:0] div_pend;
      logic             pend_valid;
      logic             clk_q;
      logic             tick_q;
      logic             wr_hit;
      logic             wrap;
      logic             start;
      logic             boundary;
      logic [CNT_W:0]   cnt_inc;
      logic [CNT_W:0]   half;

      // Per-channel decode of write target, period position and boundaries.
      always_comb begin
         wr_hit   = cfg_legal && (cfg_ch == CH_W'(g));
         wrap     = (state == ST_RUN) && (cnt == div_act - CNT_W'(1));
         start    = (state == ST_IDLE) && ch_en[g];
         boundary = start || wrap;
         cnt_inc  = {1'b0, cnt} + (CNT_W+1)'(1);
         half     = ({1'b0, div_act} + (CNT_W+1)'(1)) >> 1;
      end

      // State register.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state <= ST_IDLE;
         end else begin
            state <= state_nxt;
         end
      end

      // Next state: start on enable, park only at the end of a full period.
      always_comb begin
         state_nxt = state;
         case (state)
            ST_IDLE: if (ch_en[g]) state_nxt = ST_RUN;
            ST_RUN:  if (wrap && !ch_en[g]) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
      end

      // Output decode of the state.
      always_comb begin
         running[g] = (state == ST_RUN);
      end

      // Period counter and registered waveform/tick.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cnt    <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
         end else begin
            tick_q <= 1'b0;
            if (state == ST_IDLE) begin
               cnt   <= '0;
               clk_q <= 1'b0;
               if (ch_en[g]) begin
                  clk_q  <= 1'b1;
                  tick_q <= 1'b1;
               end
            end else if (wrap) begin
               cnt <= '0;
               if (ch_en[g]) begin
                  clk_q  <= 1'b1;
                  tick_q <= 1'b1;
               end else begin
                  clk_q <= 1'b0;
               end
            end else begin
               cnt   <= cnt_inc[CNT_W-1:0];
               clk_q <= (cnt_inc < half);
            end
         end
      end

      // Divisor hand-over: consume the pended value at a boundary, while a
      // write landing in that same cycle re-arms the pend for the next one.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            div_act    <= DEF_DIV_L;
            div_pend   <= DEF_DIV_L;
            pend_valid <= 1'b0;
         end else begin
            if (boundary && pend_valid) begin
               div_act    <= div_pend;
               pend_valid <= 1'b0;
            end
            if (wr_hit) begin
               div_pend   <= cfg_div;
               pend_valid <= 1'b1;
            end
         end
      end

      assign clk_out[g] = clk_q;
      assign tick[g]    = tick_q;
   end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog with three channels, directed
// scenarios followed by randomized configuration and enable traffic.
module tb_clk_div_prog;

   localparam int NCH = 3;

   logic           clk = 1'b0;
   logic           reset;
   logic           cfg_we;
   logic [1:0]     cfg_ch;
   logic [7:0]     cfg_div;
   logic           cfg_err;
   logic [NCH-1:0] ch_en;
   logic [NCH-1:0] clk_out;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] running;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Reference: per channel, whether it runs, position inside the period,
   // active and pending divisor.
   bit m_run  [NCH];
   int m_pos  [NCH];
   int m_div  [NCH];
   int m_pend [NCH];
   bit m_pv   [NCH];
   bit m_err;

   clk_div_prog #(.NUM_CH(NCH), .CNT_W(8), .DEF_DIV(4)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_div(cfg_div), .cfg_err(cfg_err), .ch_en(ch_en),
      .clk_out(clk_out), .tick(tick), .running(running)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_run[c] = 0; m_pos[c] = 0; m_div[c] = 4; m_pend[c] = 0; m_pv[c] = 0;
      end
      m_err = 0;
   endtask

   // One clock edge of the reference, using the inputs currently driven.
   task automatic model_step();
      bit legal;
      legal = cfg_we && (int'(cfg_ch) < NCH) && (int'(cfg_div) >= 2);
      for (int c = 0; c < NCH; c++) begin
         if (m_run[c] && m_pos[c] + 1 < m_div[c]) begin
            m_pos[c]++;
         end else begin
            if (m_run[c] || ch_en[c]) begin
               if (m_pv[c]) begin m_div[c] = m_pend[c]; m_pv[c] = 0; end
            end
            m_run[c] = ch_en[c];
            m_pos[c] = 0;
         end
         if (legal && int'(cfg_ch) == c) begin m_pend[c] = cfg_div; m_pv[c] = 1; end
      end
      m_err = cfg_we && !legal;
   endtask

   task automatic compare_all();
      logic [NCH-1:0] e_clk, e_tick, e_run;
      for (int c = 0; c < NCH; c++) begin
         e_run[c]  = m_run[c];
         e_tick[c] = m_run[c] && (m_pos[c] == 0);
         e_clk[c]  = m_run[c] && (m_pos[c] < (m_div[c] + 1) / 2);
      end
      check("clk_out", 32'(clk_out), 32'(e_clk));
      check("tick",    32'(tick),    32'(e_tick));
      check("running", 32'(running), 32'(e_run));
      check("cfg_err", 32'(cfg_err), 32'(m_err));
   endtask

   // Inputs are driven at edge+1; the edge is taken, the reference advanced and
   // outputs compared 1ns after that edge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic write(input int ch, input int dv);
      cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_div = 8'(dv);
      cycle();
      cfg_we = 1'b0;
   endtask

   // Reset asserted between edges; outputs must fall without waiting for a clock.
   task automatic pulse_reset();
      #2;
      reset = 1'b1;
      #1;
      check("rst_clk_out", 32'(clk_out), 32'd0);
      check("rst_tick",    32'(tick),    32'd0);
      check("rst_running", 32'(running), 32'd0);
      check("rst_cfg_err", 32'(cfg_err), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; ch_en = '0;
      model_reset();
      #12;
      compare_all();
      #1;
      reset = 1'b0;

      // Default divide-by-4 on channel 0 only.
      ch_en = 3'b001;
      for (int k = 0; k < 12; k++) begin
         cycle();
         check("t1_wave", 32'(clk_out[0]), 32'((k % 4) < 2));
         check("t1_tick", 32'(tick[0]),    32'((k % 4) == 0));
         check("t1_ch1",  32'({clk_out[1], running[1]}), 32'd0);
      end

      // Odd divisor programmed while idle.
      ch_en = '0;
      cycles(6);
      write(0, 5);
      ch_en = 3'b001;
      for (int k = 0; k < 10; k++) begin
         cycle();
         check("t2_wave", 32'(clk_out[0]), 32'((k % 5) < 3));
      end

      // Divisor change mid-period waits for the wrap.
      pulse_reset();
      ch_en = 3'b001;
      cycles(2);
      write(0, 3);
      cycles(8);

      // Disable mid-period, then re-enable.
      write(0, 6);
      cycles(8);
      while (!(running[0] && tick[0])) cycle();
      ch_en = 3'b000;
      cycles(8);
      ch_en = 3'b001;
      cycles(3);

      // Illegal divisor and out-of-range channel.
      write(0, 1);
      cycles(2);
      write(3, 7);
      cycles(2);
      write(1, 0);
      cycles(6);

      // Reset in the high phase discards a pending divisor.
      write(0, 7);
      while (!clk_out[0]) cycle();
      pulse_reset();
      ch_en = 3'b001;
      for (int k = 0; k < 8; k++) begin
         cycle();
         check("t6_wave", 32'(clk_out[0]), 32'((k % 4) < 2));
      end

      // Back-to-back writes plus a write on the wrap cycle.
      write(0, 2);
      write(0, 9);
      cycles(12);

      // Randomized traffic on all channels.
      ch_en = 3'b111;
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 7) == 0) ch_en[$urandom_range(0, NCH-1)] ^= 1'b1;
         if ($urandom_range(0, 3) == 0) begin
            cfg_we = 1'b1;
            cfg_ch = 2'($urandom_range(0, 3));
            cfg_div = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255))
                                                   : 8'($urandom_range(0, 9));
         end else begin
            cfg_we = 1'b0;
         end
         if ($urandom_range(0, 599) == 0) begin
            cfg_we = 1'b0;
            pulse_reset();
         end else begin
            cycle();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
